// File: rtl/muxn_skid.sv
// N-to-1 valid/ready channel mux (explicit select or round-robin) feeding a 2-entry skid buffer.
// Optional output-transfer counter port o_xfer_cnt is enabled by defining MUXN_SKID_XFER_CNT_EN.
module muxn_skid #(
  parameter int NB_DATA  = 32,
  parameter int N_INPUTS = 4,
  parameter int ARB_MODE = 0,
  localparam int NB_SEL  = (N_INPUTS > 2) ? $clog2(N_INPUTS) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_flush,
  input  logic [N_INPUTS*NB_DATA-1:0]  i_data,
  input  logic [N_INPUTS-1:0]          i_valid,
  output logic [N_INPUTS-1:0]          o_ready,
  input  logic [NB_SEL-1:0]            i_sel,
  output logic [NB_DATA-1:0]           o_data,
  output logic [NB_SEL-1:0]            o_chan,
  output logic                         o_valid,
  input  logic                         i_ready
`ifdef MUXN_SKID_XFER_CNT_EN
  ,
  output logic [15:0]                  o_xfer_cnt
`endif
);

  logic [NB_DATA-1:0] main_data, skid_data, word;
  logic [NB_SEL-1:0]  main_chan, skid_chan, g, rr_ptr;
  logic               main_valid, skid_valid;
  logic               grant_ok, in_xfer, out_xfer, can_accept;

  // Only the registered skid state gates acceptance, so o_ready never sees i_ready.
  assign can_accept = !skid_valid;
  assign out_xfer   = main_valid & i_ready;

  assign o_data  = main_data;
  assign o_chan  = main_chan;
  assign o_valid = main_valid;

  always_comb begin
    int unsigned idx;
    grant_ok = 1'b0;
    g        = '0;
    idx      = 0;
    if (ARB_MODE == 0) begin
      grant_ok = (int'(i_sel) < N_INPUTS);
      g        = i_sel;
    end else begin
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        idx = 32'(rr_ptr) + i;
        if (idx >= N_INPUTS) idx = idx - N_INPUTS;
        if (!grant_ok && i_valid[NB_SEL'(idx)]) begin
          grant_ok = 1'b1;
          g        = NB_SEL'(idx);
        end
      end
    end
  end

  always_comb begin
    o_ready = '0;
    word    = '0;
    in_xfer = 1'b0;
    for (int unsigned k = 0; k < N_INPUTS; k++) begin
      if (grant_ok && (NB_SEL'(k) == g)) begin
        word       = i_data[k*NB_DATA +: NB_DATA];
        o_ready[k] = can_accept & !i_flush & !i_reset;
        in_xfer    = o_ready[k] & i_valid[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      main_data  <= '0;
      main_chan  <= '0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_chan  <= '0;
      skid_valid <= 1'b0;
      rr_ptr     <= '0;
    end else if (i_flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      rr_ptr     <= '0;
    end else if (in_xfer) begin
      // in_xfer implies the skid entry is empty, so a draining main slot can be refilled directly.
      if (!main_valid || out_xfer) begin
        main_data  <= word;
        main_chan  <= g;
        main_valid <= 1'b1;
      end else begin
        skid_data  <= word;
        skid_chan  <= g;
        skid_valid <= 1'b1;
      end
      if (ARB_MODE != 0)
        rr_ptr <= (g == NB_SEL'(N_INPUTS-1)) ? '0 : g + 1'b1;
    end else if (out_xfer) begin
      if (skid_valid) begin
        main_data <= skid_data;
        main_chan <= skid_chan;
      end
      main_valid <= skid_valid;
      skid_valid <= 1'b0;
    end
  end

`ifdef MUXN_SKID_XFER_CNT_EN
  // Flush does not cancel a downstream transfer, so it is still counted.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      o_xfer_cnt <= '0;
    else if (out_xfer && (o_xfer_cnt != 16'hFFFF))
      o_xfer_cnt <= o_xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_muxn_skid.sv
// Directed bench for muxn_skid: one explicit-select instance and one round-robin instance.
module tb_muxn_skid;

  localparam int NB_DATA  = 32;
  localparam int N_INPUTS = 4;
  localparam int NB_SEL   = 2;

  logic clk, reset;
  logic flush0, flush1;
  logic [N_INPUTS*NB_DATA-1:0] data0, data1;
  logic [N_INPUTS-1:0] valid0, valid1, ready_o0, ready_o1;
  logic [NB_SEL-1:0] sel0, sel1, chan0, chan1;
  logic [NB_DATA-1:0] odata0, odata1;
  logic ovalid0, ovalid1, iready0, iready1;
`ifdef MUXN_SKID_XFER_CNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  int checks = 0;
  int failures = 0;

  muxn_skid #(.NB_DATA(NB_DATA), .N_INPUTS(N_INPUTS), .ARB_MODE(0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_flush(flush0), .i_data(data0), .i_valid(valid0),
    .o_ready(ready_o0), .i_sel(sel0), .o_data(odata0), .o_chan(chan0), .o_valid(ovalid0),
    .i_ready(iready0)
`ifdef MUXN_SKID_XFER_CNT_EN
    , .o_xfer_cnt(cnt0)
`endif
  );

  muxn_skid #(.NB_DATA(NB_DATA), .N_INPUTS(N_INPUTS), .ARB_MODE(1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_flush(flush1), .i_data(data1), .i_valid(valid1),
    .o_ready(ready_o1), .i_sel(sel1), .o_data(odata1), .o_chan(chan1), .o_valid(ovalid1),
    .i_ready(iready1)
`ifdef MUXN_SKID_XFER_CNT_EN
    , .o_xfer_cnt(cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; flush0 = 1'b0; flush1 = 1'b0;
    data0 = '0; data1 = '0; valid0 = '0; valid1 = '0;
    sel0 = 2'd2; sel1 = '0; iready0 = 1'b0; iready1 = 1'b0;
    tick();
    tick();
    valid0 = 4'b0100;
    #1;
    chk("reset_ready", 64'(ready_o0), 64'h0);
    chk("reset_valid", 64'(ovalid0), 64'h0);
    chk("reset_data", 64'(odata0), 64'h0);
    chk("reset_chan", 64'(chan0), 64'h0);
    valid0 = '0;
    tick();
    reset = 1'b0;

    // Explicit select, single word
    data0[2*NB_DATA +: NB_DATA] = 32'hA5A5_0002;
    valid0 = 4'b0100; iready0 = 1'b1;
    #1;
    chk("m0_ready_sel2", 64'(ready_o0), 64'h4);
    tick();
    valid0 = '0;
    #1;
    chk("m0_ovalid", 64'(ovalid0), 64'h1);
    chk("m0_odata", 64'(odata0), 64'hA5A5_0002);
    chk("m0_ochan", 64'(chan0), 64'h2);
    tick();
    chk("m0_drained", 64'(ovalid0), 64'h0);

    // Stall: three words offered, only two fit
    iready0 = 1'b0; valid0 = 4'b0100;
    data0[2*NB_DATA +: NB_DATA] = 32'h11;
    #1;
    chk("stall_ready1", 64'(ready_o0), 64'h4);
    tick();
    data0[2*NB_DATA +: NB_DATA] = 32'h22;
    #1;
    chk("stall_ready2", 64'(ready_o0), 64'h4);
    tick();
    data0[2*NB_DATA +: NB_DATA] = 32'h33;
    #1;
    chk("stall_full_ready", 64'(ready_o0), 64'h0);
    tick();
    chk("stall_hold_valid", 64'(ovalid0), 64'h1);
    chk("stall_hold_data", 64'(odata0), 64'h11);
    iready0 = 1'b1;
    #1;
    chk("stall_ready_no_iready_path", 64'(ready_o0), 64'h0);
    tick();
    chk("stall_out2", 64'(odata0), 64'h22);
    chk("stall_ready_reopen", 64'(ready_o0), 64'h4);
    tick();
    valid0 = '0;
    #1;
    chk("stall_out3", 64'(odata0), 64'h33);
    tick();
    chk("stall_empty", 64'(ovalid0), 64'h0);

    // Round-robin, all channels valid
    for (int k = 0; k < N_INPUTS; k++) data1[k*NB_DATA +: NB_DATA] = 32'h100 + 32'(k);
    valid1 = 4'b1111; iready1 = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("rr_grant", 64'(ready_o1), 64'(4'b0001 << (i % 4)));
      tick();
      chk("rr_chan", 64'(chan1), 64'(i % 4));
      chk("rr_data", 64'(odata1), 64'h100 + 64'(i % 4));
    end

    // Round-robin from rr_ptr=2 with only ch3 and ch1 valid
    valid1 = 4'b1010;
    #1;
    chk("rr_sparse_g3", 64'(ready_o1), 64'h8);
    tick();
    chk("rr_sparse_c3", 64'(chan1), 64'h3);
    chk("rr_sparse_g1", 64'(ready_o1), 64'h2);
    tick();
    chk("rr_sparse_c1", 64'(chan1), 64'h1);
    chk("rr_sparse_g3b", 64'(ready_o1), 64'h8);
    tick();
    chk("rr_sparse_c3b", 64'(chan1), 64'h3);
    valid1 = '0;
    tick();
    chk("rr_empty", 64'(ovalid1), 64'h0);

    // Flush with both entries full; rr_ptr is 1 before the flush
    iready1 = 1'b0; valid1 = 4'b0001;
    tick();
    tick();
    chk("fl_full_ready", 64'(ready_o1), 64'h0);
    chk("fl_full_valid", 64'(ovalid1), 64'h1);
    flush1 = 1'b1; valid1 = 4'b1001;
    #1;
    chk("fl_ready_in_flush", 64'(ready_o1), 64'h0);
    tick();
    flush1 = 1'b0;
    #1;
    chk("fl_ovalid", 64'(ovalid1), 64'h0);
    chk("fl_rr_reset", 64'(ready_o1), 64'h1);
    valid1 = '0;

    // Flush alone blocks acceptance even with skid space
    iready0 = 1'b0; valid0 = 4'b0100;
    data0[2*NB_DATA +: NB_DATA] = 32'h77;
    tick();
    flush0 = 1'b1;
    #1;
    chk("fl0_ready", 64'(ready_o0), 64'h0);
    tick();
    flush0 = 1'b0; valid0 = '0;
    #1;
    chk("fl0_ovalid", 64'(ovalid0), 64'h0);

    // Reset mid-stream with two buffered words
    valid0 = 4'b0100;
    data0[2*NB_DATA +: NB_DATA] = 32'h55;
    tick();
    data0[2*NB_DATA +: NB_DATA] = 32'h66;
    tick();
    valid0 = '0;
    #1;
    chk("rst_pre_valid", 64'(ovalid0), 64'h1);
    chk("rst_pre_data", 64'(odata0), 64'h55);
`ifdef MUXN_SKID_XFER_CNT_EN
    chk("cnt_pre", 64'(cnt0), 64'h4);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", 64'(ovalid0), 64'h0);
    chk("rst_data", 64'(odata0), 64'h0);
    chk("rst_chan", 64'(chan0), 64'h0);
`ifdef MUXN_SKID_XFER_CNT_EN
    chk("rst_cnt", 64'(cnt0), 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
